mod2011_residue_accumulator: RTL and testbench
==============================================

Name: mod2011_residue_accumulator

Overview:
Downstream consumer of the 6-input chunk LUT stage. Each LUT produces an 11-bit partial residue of one 6-bit chunk of a 500-bit operand X, weighted mod 2011. This block accepts those partial residues serially over a valid/ready stream and accumulates them modulo MODULUS. After the final chunk it emits X mod 2011 with a length-check flag.

Parameters:
MODULUS, 2011, modulus; must satisfy 2^(RES_W-1) < MODULUS < 2^RES_W
RES_W, 11, residue width in bits
NUM_CHUNKS, 84, chunks per frame (ceil(500/6))
CNT_W, 7, beat counter width; 2^CNT_W > NUM_CHUNKS

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  partial residue present
in_ready  out  1  block accepts a beat this cycle
in_data  in  RES_W  partial residue, nominally < MODULUS
in_last  in  1  marks final beat of frame
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_residue  out  RES_W  frame sum mod MODULUS
out_count  out  CNT_W  beats in the frame
out_len_err  out  1  frame length mismatch
out_range_err  out  1  any beat had in_data >= MODULUS (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high: state=ACCUM; acc=0; cnt=0; out_valid=0; out_residue=0; out_count=0; out_len_err=0; out_range_err=0; sticky range flag=0.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat accepted when in_valid && in_ready.
- Modular add:
  - s = acc + in_data, computed at RES_W+1 bits.
  - acc_next = (s >= MODULUS) ? s - MODULUS : s.
  - Single conditional subtract; this is exact for in-range inputs. Out-of-range inputs are reduced once only and produce no further correction.
- Frame close occurs on an accepted beat when in_last=1 or cnt == NUM_CHUNKS-1. On close:
  - out_residue <= acc_next
  - out_count <= cnt+1
  - out_len_err <= (in_last != (cnt == NUM_CHUNKS-1))
  - out_range_err <= sticky | current beat's range flag
  - acc <= 0, cnt <= 0, sticky <= 0, state -> HOLD
- Non-closing accepted beat: acc <= acc_next, cnt <= cnt+1, state stays ACCUM.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- HOLD: all out_* held stable while out_ready=0. On out_ready=1, go to ACCUM next cycle. No same-cycle input acceptance, so a bubble of one cycle per frame is required.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- in_last on the first beat gives a 1-beat frame: out_count=1, out_len_err=1 (unless NUM_CHUNKS=1).
- rst mid-frame or in HOLD discards the partial sum and any pending result; no output is produced for that frame.
- Throughput: 1 beat/cycle within a frame; NUM_CHUNKS+1 cycles minimum per frame.

Optional Feature:
Macro MOD_ACC_RANGE_CHECK_EN.
- Defined: each accepted beat compares in_data >= MODULUS and ORs the result into a sticky flag. The flag is reported on out_range_err at frame close and cleared at close or reset. The accumulator still uses the single-subtract result.
- Undefined: no comparator is built and out_range_err is tied to 0.

Test Plan:
- Reset then 84 beats of in_data=2010, in_last on beat 84 -> out_residue=1927, out_count=84, out_len_err=0, out_valid 1 cycle after the last beat.
- 2-beat frame 2010, 1 with in_last on beat 2 -> out_residue=0, out_count=2, out_len_err=1.
- 84 beats of 1 with in_last never asserted -> frame auto-closes at beat 84, out_residue=84, out_len_err=1, in_ready=0 next cycle.
- Hold out_ready=0 for 10 cycles in HOLD while driving in_valid=1 -> outputs stable, in_ready=0, no beats consumed. Release -> in_ready=1 next cycle.
- Assert rst after 40 beats of 1000, then run a clean 84-beat frame of 0 -> out_residue=0, out_count=84, with no stale result.
- (MOD_ACC_RANGE_CHECK_EN) a frame containing one beat of 2047 -> out_range_err=1. The next clean frame -> out_range_err=0. With the macro undefined -> out_range_err always 0.

Source files
------------

// File: rtl/mod2011_residue_accumulator.sv
// Serial modulo-MODULUS accumulator for chunk partial residues; emits the frame residue plus length/range flags.
// Optional input range checking is built when MOD_ACC_RANGE_CHECK_EN is defined.
module mod2011_residue_accumulator #(
  parameter int MODULUS    = 2011,
  parameter int RES_W      = 11,
  parameter int NUM_CHUNKS = 84,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_residue,
  output logic [CNT_W-1:0] out_count,
  output logic             out_len_err,
  output logic             out_range_err
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_beat;
  logic             close;
  logic [RES_W:0]   sum;
  logic [RES_W:0]   reduced;
  logic [RES_W-1:0] acc_next;

  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(NUM_CHUNKS - 1));
  assign close     = accept && (in_last || last_beat);

  // One conditional subtract: exact only while every beat is below MODULUS.
  assign sum      = {1'b0, acc} + {1'b0, in_data};
  assign reduced  = (sum >= (RES_W + 1)'(MODULUS)) ? sum - (RES_W + 1)'(MODULUS) : sum;
  assign acc_next = RES_W'(reduced);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (close) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_residue <= '0;
      out_count   <= '0;
      out_len_err <= 1'b0;
    end else if (close) begin
      out_residue <= acc_next;
      out_count   <= cnt + CNT_W'(1);
      out_len_err <= (in_last != last_beat);
      acc         <= '0;
      cnt         <= '0;
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef MOD_ACC_RANGE_CHECK_EN
  logic range_hit;
  logic sticky;

  assign range_hit = (in_data >= RES_W'(MODULUS));

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky        <= 1'b0;
      out_range_err <= 1'b0;
    end else if (close) begin
      out_range_err <= sticky | range_hit;
      sticky        <= 1'b0;
    end else if (accept) begin
      sticky <= sticky | range_hit;
    end
  end
`else
  assign out_range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod2011_residue_accumulator.sv
// Bench for mod2011_residue_accumulator: table-driven frames, scoreboard queue, and hand-written
// sequences for hold, auto-close, mid-frame reset and range flag (MOD_ACC_RANGE_CHECK_EN aware).
module tb_mod2011_residue_accumulator;

  localparam int W = 20;  // {residue[10:0], count[6:0], len_err, range_err}
`ifdef MOD_ACC_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [10:0] out_residue;
  logic [6:0]  out_count;
  logic        out_len_err;
  logic        out_range_err;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  mod2011_residue_accumulator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_residue(out_residue), .out_count(out_count),
    .out_len_err(out_len_err), .out_range_err(out_range_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare every delivered result against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got residue %0d count %0d with nothing expected",
                 out_residue, out_count);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("out_residue", int'(out_residue), int'(e[19:9]));
        chk("out_count", int'(out_count), int'(e[8:2]));
        chk("out_len_err", int'(out_len_err), int'(e[1]));
        chk("out_range_err", int'(out_range_err), int'(e[0]));
      end
    end
  end

  // driver: n beats, first beat d_first, rest d_rest; in_last on final beat if last
  task automatic send_frame(input int n, input logic [10:0] d_first, input logic [10:0] d_rest,
                            input bit last, input bit closes);
    for (int b = 0; b < n; b++) begin
      int waited;
      in_valid = 1'b1;
      in_data  = (b == 0) ? d_first : d_rest;
      in_last  = last && (b == n - 1);
      waited = 0;
      while (!in_ready && waited < 200) begin
        tick();
        waited++;
      end
      if (!in_ready) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (closes) begin
      chk("latency_out_valid", int'(out_valid), 1);
      chk("close_in_ready", int'(in_ready), 0);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(input logic [10:0] r, input logic [6:0] c,
                                            input bit l, input bit g);
    return {r, c, l, g};
  endfunction

  typedef struct {
    int          n;
    logic [10:0] d_first;
    logic [10:0] d_rest;
    bit          last;
    logic [10:0] exp_res;
    logic [6:0]  exp_cnt;
    bit          exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{84, 11'd2010, 11'd2010, 1'b1, 11'd1927, 7'd84, 1'b0};
    vecs[1] = '{2,  11'd2010, 11'd1,    1'b1, 11'd0,    7'd2,  1'b1};
    vecs[2] = '{84, 11'd1,    11'd1,    1'b0, 11'd84,   7'd84, 1'b1};
    vecs[3] = '{1,  11'd5,    11'd0,    1'b1, 11'd5,    7'd1,  1'b1};
    vecs[4] = '{84, 11'd0,    11'd0,    1'b1, 11'd0,    7'd84, 1'b0};
    vecs[5] = '{10, 11'd1000, 11'd1500, 1'b1, 11'd423,  7'd10, 1'b1};
    vecs[6] = '{84, 11'd7,    11'd2000, 1'b1, 11'd1105, 7'd84, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_residue", int'(out_residue), 0);
    chk("reset_out_count", int'(out_count), 0);
    chk("reset_out_len_err", int'(out_len_err), 0);
    chk("reset_out_range_err", int'(out_range_err), 0);

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(pack_exp(vecs[i].exp_res, vecs[i].exp_cnt, vecs[i].exp_len, 1'b0));
      send_frame(vecs[i].n, vecs[i].d_first, vecs[i].d_rest, vecs[i].last, 1'b1);
    end

    // hold with out_ready low while the source keeps offering beats
    tick();
    out_ready = 1'b0;
    exp_q.push_back(pack_exp(11'd500, 7'd3, 1'b1, 1'b0));
    send_frame(3, 11'd100, 11'd200, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 11'd77;
    for (int c = 0; c < 10; c++) begin
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_residue", int'(out_residue), 500);
      chk("hold_out_count", int'(out_count), 3);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", int'(in_ready), 1);
    in_valid = 1'b0;
    exp_q.push_back(pack_exp(11'd9, 7'd2, 1'b1, 1'b0));
    send_frame(2, 11'd4, 11'd5, 1'b1, 1'b1);

    // reset mid-frame discards the partial sum
    tick();
    send_frame(40, 11'd1000, 11'd1000, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    exp_q.push_back(pack_exp(11'd0, 7'd84, 1'b0, 1'b0));
    send_frame(84, 11'd0, 11'd0, 1'b1, 1'b1);

    // out-of-range beat: flag only when the range checker is built
    tick();
    exp_q.push_back(pack_exp(11'd40, 7'd5, 1'b1, RANGE_EN));
    send_frame(5, 11'd2047, 11'd1, 1'b1, 1'b1);
    exp_q.push_back(pack_exp(11'd30, 7'd3, 1'b1, 1'b0));
    send_frame(3, 11'd10, 11'd10, 1'b1, 1'b1);

    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
